// File: rtl/prog_loader_pkg.sv
//------------------------------------------------------------------------------
// prog_loader_pkg : shared constants and state encodings for the program loader
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         PROG_DEPTH   = 16;
  localparam int         HOLD_CYCLES  = 16;
  localparam int         TIMEOUT_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader_uart_rx.sv
//------------------------------------------------------------------------------
// uart_rx : 8N1 receiver with two-flop synchronizer, mid-bit sampling
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int DIV = 234
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic [7:0] data_o
);

  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

  logic            sync1_q, sync2_q, line_prev_q;
  rx_state_t       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            valid_q, ferr_q;
  logic [7:0]      data_q;
  logic            start_edge_d, bit_end_d;

  assign start_edge_d = line_prev_q & ~sync2_q;
  assign bit_end_d    = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      sync1_q     <= rxd_i;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (start_edge_d) state_q <= RX_START;
        end
        RX_START: begin
          // Re-check mid start bit so a glitch does not launch a byte.
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (bit_end_d) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (bit_end_d) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync2_q) begin
              valid_q <= 1'b1;
              data_q  <= shift_q;
            end else begin
              ferr_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign data_o       = data_q;

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
//------------------------------------------------------------------------------
// prog_loader : loads a checksummed 16-byte program over UART, gates CPU reset
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       we,
  output logic [3:0] waddr,
  output logic [7:0] wdata,
  output logic       cpu_rst,
  output logic       busy,
  output logic       err
);

  localparam int DIV        = CLK_HZ / BAUD;
  localparam int TMO_CYCLES = TIMEOUT_BITS * DIV;
  localparam int TW         = $clog2(TMO_CYCLES + 1);
  localparam int AW         = $clog2(PROG_DEPTH);
  localparam int HW         = $clog2(HOLD_CYCLES);

  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_data;

  state_t        state_q;
  logic          we_q, cpu_rst_q, busy_q, err_q;
  logic [AW-1:0] waddr_q, count_q;
  logic [7:0]    wdata_q, sum_q;
  logic [TW-1:0] tmo_q;
  logic [HW-1:0] hold_q;
  logic          sync_seen_d;

  uart_rx #(
    .DIV (DIV)
  ) u_rx (
    .clk_i        (clk),
    .rst_ni       (rst),
    .rxd_i        (rxd),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr),
    .data_o       (rx_data)
  );

  assign sync_seen_d = rx_valid && (rx_data == SYNC_BYTE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      hold_q    <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (state_q == ST_IDLE) cpu_rst_q <= 1'b1;
          if (sync_seen_d) begin
            state_q   <= ST_LOAD;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            count_q   <= '0;
            sum_q     <= '0;
            tmo_q     <= '0;
          end
        end
        ST_LOAD, ST_CHECK: begin
          if (rx_ferr || (!rx_valid && tmo_q == TW'(TMO_CYCLES - 1))) begin
            state_q <= ST_ERROR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (rx_valid) begin
            tmo_q <= '0;
            if (state_q == ST_LOAD) begin
              we_q    <= 1'b1;
              waddr_q <= count_q;
              wdata_q <= rx_data;
              count_q <= count_q + AW'(1);
              sum_q   <= sum_q + rx_data;
              if (count_q == AW'(PROG_DEPTH - 1)) state_q <= ST_CHECK;
            end else begin
              busy_q <= 1'b0;
              if (rx_data == sum_q) begin
                state_q <= ST_HOLD;
                hold_q  <= '0;
                err_q   <= 1'b0;
              end else begin
                state_q <= ST_ERROR;
                err_q   <= 1'b1;
              end
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_HOLD: begin
          // Keep the CPU in reset a little longer so the last RAM write settles.
          if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            state_q   <= ST_IDLE;
            cpu_rst_q <= 1'b1;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign cpu_rst = cpu_rst_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

`default_nettype wire
